param_accumulator: RTL and testbench



---
 rtl/param_accumulator.sv | 202 ++++++++++++++++++++
 tb/tb_param_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_accumulator.sv
// param_accumulator: WIDTH-bit accumulator with ADD/SUB/LOAD and an
// iterative unsigned shift-add MUL, fed through a valid/ready handshake.
// Exports carry, signed-overflow and zero flags to the surrounding ALU.
// Optional build macro: ACC_SATURATE_EN -- clamps ADD/SUB results on signed
// overflow and MUL results on product overflow instead of wrapping.
module param_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             busy,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

`ifdef ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t               state_q,  state_d;
  logic [WIDTH-1:0]     acc_q,    acc_d;
  logic                 carry_q,  carry_d;
  logic                 ovf_q,    ovf_d;
  logic                 done_q,   done_d;
  logic                 busy_q,   busy_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q,   prod_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic                 add_ovf_s;
  logic                 sub_ovf_s;
  logic [2*WIDTH-1:0]   prod_nxt_s;
  logic                 last_iter_s;
  logic                 accept_s;
`ifdef ACC_SATURATE_EN
  logic [WIDTH-1:0]     sat_val_s;
`endif

  assign op_ready = (state_q == ST_IDLE) && !rst;
  assign accept_s = op_valid && op_ready;

  // Datapath helpers: adder, subtractor, overflow detect, one shift-add step.
  always_comb begin
    sum_s       = {1'b0, acc_q} + {1'b0, operand};
    diff_s      = {1'b0, acc_q} + {1'b0, ~operand} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf_s   = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != acc_q[WIDTH-1]);
    sub_ovf_s   = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                  (diff_s[WIDTH-1] != acc_q[WIDTH-1]);
    prod_nxt_s  = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    last_iter_s = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ACC_SATURATE_EN
    // On signed overflow the true result has the sign of the accumulator.
    sat_val_s   = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
  end

  // Next-state logic for the FSM, accumulator, flags and multiply engine.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_code)
            OP_ADD: begin
`ifdef ACC_SATURATE_EN
              acc_d = add_ovf_s ? sat_val_s : sum_s[WIDTH-1:0];
`else
              acc_d = sum_s[WIDTH-1:0];
`endif
              carry_d = sum_s[WIDTH];
              ovf_d   = add_ovf_s;
              done_d  = 1'b1;
            end
            OP_SUB: begin
`ifdef ACC_SATURATE_EN
              acc_d = sub_ovf_s ? sat_val_s : diff_s[WIDTH-1:0];
`else
              acc_d = diff_s[WIDTH-1:0];
`endif
              carry_d = diff_s[WIDTH];
              ovf_d   = sub_ovf_s;
              done_d  = 1'b1;
            end
            OP_LOAD: begin
              acc_d   = operand;
              carry_d = 1'b0;
              ovf_d   = 1'b0;
              done_d  = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, acc_q};
              mplier_d = operand;
              prod_d   = {(2*WIDTH){1'b0}};
              cnt_d    = {CNT_W{1'b0}};
              busy_d   = 1'b1;
              state_d  = ST_MUL;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        prod_d   = prod_nxt_s;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (last_iter_s) begin
          ovf_d   = |prod_nxt_s[2*WIDTH-1:WIDTH];
`ifdef ACC_SATURATE_EN
          acc_d   = (|prod_nxt_s[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}}
                                                   : prod_nxt_s[WIDTH-1:0];
`else
          acc_d   = prod_nxt_s[WIDTH-1:0];
`endif
          carry_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; synchronous reset overrides everything, including MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc   = acc_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = (acc_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_param_accumulator.sv
// Testbench for param_accumulator: an 8-bit instance for directed vectors and
// a 16-bit instance for a random op stream, both checked every cycle against
// an arithmetic reference model.
module tb_param_accumulator;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        op_v [2] = '{1'b0, 1'b0};
  logic [1:0]  op_c [2] = '{2'b00, 2'b00};
  logic [15:0] op_o [2] = '{16'h0000, 16'h0000};

  logic        rdy8, done8, busy8, carry8, ovf8, zero8;
  logic [7:0]  acc8;
  logic        rdy16, done16, busy16, carry16, ovf16, zero16;
  logic [15:0] acc16;

  param_accumulator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .op_valid(op_v[0]), .op_ready(rdy8),
    .op_code(op_c[0]), .operand(op_o[0][7:0]), .acc(acc8), .done(done8),
    .busy(busy8), .carry(carry8), .ovf(ovf8), .zero(zero8));

  param_accumulator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .op_valid(op_v[1]), .op_ready(rdy16),
    .op_code(op_c[1]), .operand(op_o[1]), .acc(acc16), .done(done16),
    .busy(busy16), .carry(carry16), .ovf(ovf16), .zero(zero16));

  logic [15:0] d_acc [2];
  logic        d_rdy [2], d_done [2], d_busy [2], d_c [2], d_v [2], d_z [2];
  assign d_acc[0] = {8'h00, acc8};  assign d_acc[1] = acc16;
  assign d_rdy[0] = rdy8;           assign d_rdy[1] = rdy16;
  assign d_done[0] = done8;         assign d_done[1] = done16;
  assign d_busy[0] = busy8;         assign d_busy[1] = busy16;
  assign d_c[0] = carry8;           assign d_c[1] = carry16;
  assign d_v[0] = ovf8;             assign d_v[1] = ovf16;
  assign d_z[0] = zero8;            assign d_z[1] = zero16;

  // Reference model state
  longint m_acc [2] = '{0, 0};
  longint m_prod [2] = '{0, 0};
  int     m_rem [2] = '{0, 0};
  bit     m_c [2] = '{1'b0, 1'b0};
  bit     m_v [2] = '{1'b0, 1'b0};
  bit     m_done [2] = '{1'b0, 1'b0};

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic int wdt(int i);
    return (i == 0) ? 8 : 16;
  endfunction

  // Model: one clock edge for instance i, from plain integer arithmetic.
  function automatic void model_step(int i);
    int w = wdt(i);
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint a, b, sa, sb, r;
    if (rst) begin
      m_acc[i] = 0; m_c[i] = 1'b0; m_v[i] = 1'b0; m_done[i] = 1'b0; m_rem[i] = 0;
    end else begin
      m_done[i] = 1'b0;
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_v[i] = (m_prod[i] >> w) != 0;
          m_c[i] = 1'b0;
          m_acc[i] = (SAT && m_v[i]) ? mask : (m_prod[i] & mask);
          m_done[i] = 1'b1;
        end
      end else if (op_v[i]) begin
        a  = m_acc[i];
        b  = longint'(op_o[i]) & mask;
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        case (op_c[i])
          2'b00, 2'b01: begin
            r = (op_c[i] == 2'b00) ? sa + sb : sa - sb;
            m_c[i] = (op_c[i] == 2'b00) ? ((a + b) > mask) : (a >= b);
            m_v[i] = (r >= half) || (r < -half);
            if (SAT && m_v[i]) m_acc[i] = (r > 0) ? half - 1 : half;
            else m_acc[i] = ((op_c[i] == 2'b00) ? a + b : a - b) & mask;
            m_done[i] = 1'b1;
          end
          2'b10: begin
            m_acc[i] = b; m_c[i] = 1'b0; m_v[i] = 1'b0; m_done[i] = 1'b1;
          end
          default: begin
            m_prod[i] = a * b;
            m_rem[i] = w;
          end
        endcase
      end
    end
  endfunction

  // Advance the model on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare both DUTs against the model on every falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("acc[%0d]", i), 32'(d_acc[i]), 32'(m_acc[i]));
        chk($sformatf("carry[%0d]", i), 32'(d_c[i]), 32'(m_c[i]));
        chk($sformatf("ovf[%0d]", i), 32'(d_v[i]), 32'(m_v[i]));
        chk($sformatf("done[%0d]", i), 32'(d_done[i]), 32'(m_done[i]));
        chk($sformatf("busy[%0d]", i), 32'(d_busy[i]), 32'(m_rem[i] > 0));
        chk($sformatf("zero[%0d]", i), 32'(d_z[i]), 32'(m_acc[i] == 0));
        chk($sformatf("ready[%0d]", i), 32'(d_rdy[i]), 32'((m_rem[i] == 0) && !rst));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] code, input logic [15:0] opnd);
    int n = 0;
    op_c[i] = code; op_o[i] = opnd; op_v[i] = 1'b1;
    while (d_rdy[i] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("accept_wait[%0d]", i), 32'(d_rdy[i]), 32'd1);
    tick();
    op_v[i] = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [15:0] acc_e, input logic c_e,
                     input logic v_e);
    chk({nm, "_acc"}, 32'(d_acc[0]), 32'(acc_e));
    chk({nm, "_model_acc"}, 32'(m_acc[0]), 32'(acc_e));
    chk({nm, "_carry"}, 32'(d_c[0]), 32'(c_e));
    chk({nm, "_ovf"}, 32'(d_v[0]), 32'(v_e));
    chk({nm, "_model_ovf"}, 32'(m_v[0]), 32'(v_e));
  endtask

  initial begin
    logic [1:0]  code;
    logic [15:0] opnd;
    repeat (3) @(posedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_acc", 32'(acc8), 32'h0);
    chk("rst_zero", 32'(zero8), 32'd1);
    chk("rst_ready", 32'(rdy8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);

    issue(0, 2'b10, 16'h00F0);
    chk("load_done", 32'(done8), 32'd1);
    issue(0, 2'b00, 16'h0020);
    chk("add_done", 32'(done8), 32'd1);
    pin("add", 16'h0010, 1'b1, 1'b0);

    issue(0, 2'b10, 16'h0005);
    issue(0, 2'b01, 16'h0007);
    pin("sub", 16'h00FE, 1'b0, 1'b0);

    issue(0, 2'b10, 16'h007F);
    issue(0, 2'b00, 16'h0001);
    pin("add_ovf", SAT ? 16'h007F : 16'h0080, 1'b0, 1'b1);

    issue(0, 2'b10, 16'h0080);
    issue(0, 2'b01, 16'h0001);
    pin("sub_ovf", SAT ? 16'h0080 : 16'h007F, 1'b1, 1'b1);

    // MUL 0x0C * 0x0B with an ADD request held during the multiply
    issue(0, 2'b10, 16'h000C);
    issue(0, 2'b11, 16'h000B);
    chk("mul_busy_first", 32'(busy8), 32'd1);
    op_c[0] = 2'b00; op_o[0] = 16'h0001; op_v[0] = 1'b1;
    repeat (7) tick();
    chk("mul_busy_last", 32'(busy8), 32'd1);
    chk("mul_ready_last", 32'(rdy8), 32'd0);
    chk("mul_acc_hold", 32'(acc8), 32'h0C);
    tick();
    chk("mul_done", 32'(done8), 32'd1);
    chk("mul_ready_done", 32'(rdy8), 32'd1);
    pin("mul", 16'h0084, 1'b0, 1'b0);
    tick();
    op_v[0] = 1'b0;
    chk("held_add_done", 32'(done8), 32'd1);
    pin("held_add", 16'h0085, 1'b0, 1'b0);

    issue(0, 2'b10, 16'h0020);
    issue(0, 2'b11, 16'h0010);
    repeat (8) tick();
    chk("mulovf_done", 32'(done8), 32'd1);
    chk("mulovf_zero", 32'(zero8), SAT ? 32'd0 : 32'd1);
    pin("mulovf", SAT ? 16'h00FF : 16'h0000, 1'b0, 1'b1);

    // Reset in the middle of a multiply
    issue(0, 2'b10, 16'h0003);
    issue(0, 2'b11, 16'h0005);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("abort_acc", 32'(acc8), 32'h0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_zero", 32'(zero8), 32'd1);
    chk("abort_ready", 32'(rdy8), 32'd1);
    repeat (12) tick();

    // Random stream on the 16-bit instance
    for (int k = 0; k < 1000; k++) begin
      code = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: opnd = 16'h0000;
        1: opnd = 16'h7FFF;
        2: opnd = 16'h8000;
        3: opnd = 16'hFFFF;
        4: opnd = 16'($urandom_range(0, 255));
        default: opnd = 16'($urandom);
      endcase
      issue(1, code, opnd);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
